// File: rtl/nand_sweep_checker_if.sv
// Bundle of the nand_sweep_checker control, status and cell-facing signals.
// The slave modport is the checker; the master modport is its controller plus the cell.
interface nand_sweep_checker_if #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned SETTLE_W = 4
);
    logic                ena;
    logic                start;
    logic [SETTLE_W-1:0] settle;
    logic [CNT_W-1:0]    sweeps;
    logic                drv_a;
    logic                drv_b;
    logic                cell_y;
    logic                busy;
    logic                done;
    logic                pass;
    logic [CNT_W-1:0]    err_cnt;
    logic [3:0]          fail_vec;

    modport master (
        output ena, start, settle, sweeps, cell_y,
        input  drv_a, drv_b, busy, done, pass, err_cnt, fail_vec
    );

    modport slave (
        input  ena, start, settle, sweeps, cell_y,
        output drv_a, drv_b, busy, done, pass, err_cnt, fail_vec
    );
endinterface

// File: rtl/nand_sweep_checker.sv
// Drives a nand2 test cell through all four input vectors, samples its output
// through a 2-flop synchroniser and accumulates mismatch status.
module nand_sweep_checker #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned SETTLE_W = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    nand_sweep_checker_if.slave bus
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DRIVE  = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [1:0]          sync_q;
    logic                y_s;
    logic                exp_y;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [SETTLE_W:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    sweeps_q, sweeps_d;
    logic [CNT_W-1:0]    sweep_cnt_q, sweep_cnt_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic [1:0]          idx_q, idx_d;
    logic                drv_a_q, drv_a_d, drv_b_q, drv_b_d;
    logic                pass_q, pass_d;
    logic [3:0]          fail_q, fail_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], bus.cell_y};
        end
    end

    assign y_s   = sync_q[1];
    assign exp_y = (idx_q != 2'd3);

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        wait_d      = wait_q;
        sweeps_d    = sweeps_q;
        sweep_cnt_d = sweep_cnt_q;
        err_cnt_d   = err_cnt_q;
        idx_d       = idx_q;
        drv_a_d     = drv_a_q;
        drv_b_d     = drv_b_q;
        pass_d      = pass_q;
        fail_d      = fail_q;

        case (state_q)
            ST_IDLE: begin
                drv_a_d = 1'b0;
                drv_b_d = 1'b0;
                if (bus.start && bus.ena) begin
                    settle_d    = bus.settle;
                    sweeps_d    = bus.sweeps;
                    err_cnt_d   = '0;
                    fail_d      = 4'b0000;
                    pass_d      = 1'b0;
                    idx_d       = 2'd0;
                    sweep_cnt_d = '0;
                    state_d     = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                drv_a_d = idx_q[1];
                drv_b_d = idx_q[0];
                wait_d  = {1'b0, settle_q} + (SETTLE_W + 1)'(2);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_q == (SETTLE_W + 1)'(1)) begin
                    state_d = ST_SAMPLE;
                end else begin
                    wait_d = wait_q - (SETTLE_W + 1)'(1);
                end
            end
            ST_SAMPLE: begin
                if (y_s != exp_y) begin
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                    fail_d[idx_q] = 1'b1;
                end
                if (idx_q == 2'd3 && sweep_cnt_q == sweeps_q) begin
                    // pass must include this final sample, so use the next-state count
                    pass_d  = (err_cnt_d == '0);
                    drv_a_d = 1'b0;
                    drv_b_d = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        sweep_cnt_d = sweep_cnt_q + CNT_W'(1);
                    end
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort discards any in-flight sample update and any pending completion.
        if (!bus.ena && state_q != ST_IDLE) begin
            state_d   = ST_IDLE;
            drv_a_d   = 1'b0;
            drv_b_d   = 1'b0;
            err_cnt_d = err_cnt_q;
            fail_d    = fail_q;
            pass_d    = pass_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            settle_q    <= '0;
            wait_q      <= '0;
            sweeps_q    <= '0;
            sweep_cnt_q <= '0;
            err_cnt_q   <= '0;
            idx_q       <= 2'd0;
            drv_a_q     <= 1'b0;
            drv_b_q     <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 4'b0000;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            wait_q      <= wait_d;
            sweeps_q    <= sweeps_d;
            sweep_cnt_q <= sweep_cnt_d;
            err_cnt_q   <= err_cnt_d;
            idx_q       <= idx_d;
            drv_a_q     <= drv_a_d;
            drv_b_q     <= drv_b_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
        end
    end

    assign bus.drv_a    = drv_a_q;
    assign bus.drv_b    = drv_b_q;
    assign bus.busy     = (state_q == ST_DRIVE) || (state_q == ST_WAIT) || (state_q == ST_SAMPLE);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.pass     = pass_q;
    assign bus.err_cnt  = err_cnt_q;
    assign bus.fail_vec = fail_q;

endmodule

// File: tb/tb_nand_sweep_checker.sv
// Directed bench for nand_sweep_checker: table-driven full runs against several
// cell models, plus hand-written abort, reset, and start-handling sequences.
module tb_nand_sweep_checker;

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned SETTLE_W = 4;
    localparam int          LIMIT    = 6000;

    // Cell models: 0 = nand with dly cycles of delay, 1 = stuck at 0, 2 = stuck at 1.
    localparam logic [1:0] M_NAND = 2'd0;
    localparam logic [1:0] M_ST0  = 2'd1;
    localparam logic [1:0] M_ST1  = 2'd2;

    typedef struct {
        logic [1:0] mode;
        int         dly;
        logic [3:0] settle;
        logic [7:0] sweeps;
        int         len;
        logic [7:0] err;
        logic [3:0] fail;
        logic       pass;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = M_NAND;
    int         dly = 0;
    logic [7:0] dl;
    logic       cy;
    int         n_checks = 0;
    int         n_err = 0;
    logic [15:0] seq;
    int          nchg;

    always #5 clk = ~clk;

    nand_sweep_checker_if #(.CNT_W(CNT_W), .SETTLE_W(SETTLE_W)) bus ();

    nand_sweep_checker #(.CNT_W(CNT_W), .SETTLE_W(SETTLE_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Delay line: dl[k] in a cycle holds the nand value of k+1 cycles earlier.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) dl <= '1;
        else        dl <= {dl[6:0], ~(bus.drv_a & bus.drv_b)};
    end

    always_comb begin
        cy = ~(bus.drv_a & bus.drv_b);
        if (mode == M_ST0)      cy = 1'b0;
        else if (mode == M_ST1) cy = 1'b1;
        else if (dly > 0)       cy = dl[dly-1];
    end
    assign bus.cell_y = cy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Starts a run and counts cycles (cycle 1 = first after the accepting edge) until done.
    task automatic run(input logic [1:0] m, input int d, input logic [3:0] s,
                       input logic [7:0] sw, output int cyc, output logic busy1);
        logic [1:0] prev;
        @(negedge clk);
        mode = m; dly = d; bus.settle = s; bus.sweeps = sw; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        cyc = 0; seq = '0; nchg = 0; busy1 = 1'b0;
        prev = {bus.drv_a, bus.drv_b};
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) busy1 = bus.busy;
            if ({bus.drv_a, bus.drv_b} != prev) begin
                prev = {bus.drv_a, bus.drv_b};
                seq  = {seq[13:0], prev};
                nchg++;
            end
        end while (!bus.done && cyc < LIMIT);
    endtask

    task automatic wait_done(inout int cyc);
        while (!bus.done && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    vec_t vecs[7];
    int   cyc;
    logic busy1;
    int   seen;

    initial begin
        vecs[0] = '{M_NAND, 0, 4'd0, 8'd0,   17,   8'd0,   4'b0000, 1'b1};
        vecs[1] = '{M_ST1,  0, 4'd2, 8'd3,   97,   8'd4,   4'b1000, 1'b0};
        vecs[2] = '{M_ST0,  0, 4'd0, 8'd255, 4097, 8'd255, 4'b0111, 1'b0};
        vecs[3] = '{M_NAND, 5, 4'd4, 8'd0,   33,   8'd1,   4'b1000, 1'b0};
        vecs[4] = '{M_NAND, 5, 4'd5, 8'd0,   37,   8'd0,   4'b0000, 1'b1};
        vecs[5] = '{M_NAND, 0, 4'd3, 8'd1,   57,   8'd0,   4'b0000, 1'b1};
        vecs[6] = '{M_NAND, 2, 4'd1, 8'd0,   21,   8'd1,   4'b1000, 1'b0};

        bus.ena = 1'b1; bus.start = 1'b0; bus.settle = '0; bus.sweeps = '0;
        #23;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_pass", bus.pass, 0);
        chk("rst_err", bus.err_cnt, 0);
        chk("rst_fail", bus.fail_vec, 0);
        chk("rst_drv", {bus.drv_a, bus.drv_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run(vecs[i].mode, vecs[i].dly, vecs[i].settle, vecs[i].sweeps, cyc, busy1);
            chk($sformatf("v%0d_busy_c1", i), busy1, 1);
            chk($sformatf("v%0d_len", i), cyc, vecs[i].len);
            chk($sformatf("v%0d_busy_at_done", i), bus.busy, 0);
            chk($sformatf("v%0d_err", i), bus.err_cnt, vecs[i].err);
            chk($sformatf("v%0d_fail", i), bus.fail_vec, vecs[i].fail);
            chk($sformatf("v%0d_pass", i), bus.pass, vecs[i].pass);
            if (i == 0) begin
                chk("v0_drv_changes", nchg, 4);
                chk("v0_drv_seq", seq[7:0], 8'b01_10_11_00);
            end
            @(negedge clk);
            chk($sformatf("v%0d_done_1cyc", i), bus.done, 0);
            chk($sformatf("v%0d_pass_hold", i), bus.pass, vecs[i].pass);
            chk($sformatf("v%0d_drv_idle", i), {bus.drv_a, bus.drv_b}, 0);
        end

        // Abort during WAIT of idx 2 (cycles 16..20 with settle=3); idx 0,1 already failed.
        @(negedge clk);
        mode = M_ST0; dly = 0; bus.settle = 4'd3; bus.sweeps = 8'd0; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (17) @(negedge clk);
        chk("abort_pre_busy", bus.busy, 1);
        bus.ena = 1'b0;
        @(negedge clk);
        chk("abort_busy", bus.busy, 0);
        chk("abort_drv", {bus.drv_a, bus.drv_b}, 0);
        chk("abort_pass", bus.pass, 0);
        chk("abort_err_hold", bus.err_cnt, 2);
        chk("abort_fail_hold", bus.fail_vec, 4'b0011);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.done) seen++;
            @(negedge clk);
        end
        chk("abort_no_done", seen, 0);
        bus.ena = 1'b1;

        // Asynchronous reset mid-run.
        @(negedge clk);
        mode = M_ST0; bus.settle = 4'd0; bus.sweeps = 8'd0; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst_pre_err", bus.err_cnt, 2);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_err", bus.err_cnt, 0);
        chk("midrst_fail", bus.fail_vec, 0);
        chk("midrst_drv", {bus.drv_a, bus.drv_b}, 0);
        chk("midrst_done_pass", {bus.done, bus.pass}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Start pulse while busy, with a different settle, must not alter the run.
        mode = M_NAND; bus.settle = 4'd0; bus.sweeps = 8'd0; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        cyc = 0;
        repeat (5) begin @(negedge clk); cyc++; end
        bus.start = 1'b1; bus.settle = 4'd9;
        @(negedge clk); cyc++;
        bus.start = 1'b0;
        wait_done(cyc);
        chk("busy_start_len", cyc, 17);
        chk("busy_start_pass", bus.pass, 1);
        bus.settle = 4'd0;

        // start held high: back-to-back runs, status cleared at each new start.
        @(negedge clk);
        mode = M_ST1; bus.start = 1'b1;
        @(posedge clk);
        #1 cyc = 0;
        @(negedge clk); cyc++;
        wait_done(cyc);
        chk("hold_len1", cyc, 17);
        chk("hold_err1", bus.err_cnt, 1);
        mode = M_NAND;
        @(negedge clk);
        chk("hold_idle_gap", bus.busy, 0);
        @(negedge clk);
        chk("hold_busy2", bus.busy, 1);
        chk("hold_err_clr", bus.err_cnt, 0);
        chk("hold_fail_clr", bus.fail_vec, 0);
        cyc = 1;
        wait_done(cyc);
        chk("hold_len2", cyc, 17);
        chk("hold_pass2", bus.pass, 1);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("hold_stop", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
